// File: rtl/dmem_pkg.sv
// Shared data-memory definitions: access-size encodings, load FSM states and
// the load lane-select / extension helper.
package dmem_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HW   = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  // Pick the addressed byte/halfword out of a RAM word and extend it.
  function automatic logic [DATA_WIDTH-1:0] load_format(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            off,
    input logic [1:0]            size,
    input logic                  sgn
  );
    logic [7:0]            b;
    logic [15:0]           h;
    logic [DATA_WIDTH-1:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{sgn & b[7]}}, b};
      SIZE_HW:   r = {{16{sgn & h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Synchronous single-port RAM, 2^ADDR_WIDTH x 32, byte write enables and
// registered read data.
module dmem_ram #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder: byte/halfword/word loads and stores with lane steering,
// extension, PC stall and fault reporting. DMEM_MISALIGN_TRAP_EN traps misalignment.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  input  logic        re_in,
  input  logic        we_in,
  input  logic [1:0]  size_in,
  input  logic        signed_in,
  output logic [31:0] rdata_out,
  output logic        rdata_valid_out,
  output logic        stall_out,
  output logic        fault_out,
  output logic [31:0] fault_addr_out
);

  state_t      state_q, state_d;
  logic [1:0]  off_q, size_q;
  logic        sgn_q;
  logic        illegal, reject, load_ok, store_ok, fault_d;
  logic [1:0]  off_eff;
  logic [3:0]  be;
  logic [31:0] wdata_lane, ram_rdata;
  logic [31:0] rdata_q, fault_addr_q;
  logic        valid_q, fault_q;

  // Request decode, store steering and next state
  always_comb begin
    state_d    = state_q;
    illegal    = (re_in & we_in) | ((re_in | we_in) & (size_in == 2'b10));
    reject     = illegal;
    off_eff    = addr_in[1:0];
    be         = 4'b0000;
    wdata_lane = wdata_in;
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((re_in | we_in) &&
        (((size_in == SIZE_HW) && addr_in[0]) ||
         ((size_in == SIZE_WORD) && (addr_in[1:0] != 2'b00))))
      reject = 1'b1;
`else
    if (size_in == SIZE_HW)        off_eff = {addr_in[1], 1'b0};
    else if (size_in == SIZE_WORD) off_eff = 2'b00;
`endif
    load_ok  = (state_q == IDLE) & re_in & ~we_in & ~reject;
    store_ok = (state_q == IDLE) & we_in & ~re_in & ~reject;
    fault_d  = (state_q == IDLE) & reject;

    case (size_in)
      SIZE_BYTE: begin
        wdata_lane = {4{wdata_in[7:0]}};
        be         = 4'(4'b0001 << off_eff);
      end
      SIZE_HW: begin
        wdata_lane = {2{wdata_in[15:0]}};
        be         = off_eff[1] ? 4'b1100 : 4'b0011;
      end
      default: be = 4'b1111;
    endcase
    if (!store_ok) be = 4'b0000;

    case (state_q)
      IDLE:    if (load_ok) state_d = LOAD;
      LOAD:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Load capture, result formatting and fault reporting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      off_q        <= 2'b00;
      size_q       <= SIZE_BYTE;
      sgn_q        <= 1'b0;
      rdata_q      <= 32'd0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      fault_addr_q <= 32'd0;
    end else begin
      valid_q <= (state_q == LOAD);
      fault_q <= fault_d;
      if (fault_d) fault_addr_q <= addr_in;
      if (load_ok) begin
        off_q  <= off_eff;
        size_q <= size_in;
        sgn_q  <= signed_in;
      end
      if (state_q == LOAD) rdata_q <= load_format(ram_rdata, off_q, size_q, sgn_q);
    end
  end

  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .en    (load_ok | store_ok),
    .be    (be),
    .addr  (addr_in[ADDR_WIDTH+1:2]),
    .wdata (wdata_lane),
    .rdata (ram_rdata)
  );

  assign stall_out       = load_ok | (state_q == LOAD);
  assign rdata_out       = rdata_q;
  assign rdata_valid_out = valid_q;
  assign fault_out       = fault_q;
  assign fault_addr_out  = fault_addr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl; expected load data is queued at request
// time and popped when the valid pulse arrives.
module tb_data_mem_ctrl;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b11;

  logic        clk, rst;
  logic [31:0] addr, wdata;
  logic        re, we, sgn;
  logic [1:0]  size;
  logic [31:0] rdata_out, fault_addr_out;
  logic        rdata_valid_out, stall_out, fault_out;

  int checks = 0;
  int errors = 0;
  int vcnt   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  mem_m [4096];

  data_mem_ctrl #(.ADDR_WIDTH(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .addr_in         (addr),
    .wdata_in        (wdata),
    .re_in           (re),
    .we_in           (we),
    .size_in         (size),
    .signed_in       (sgn),
    .rdata_out       (rdata_out),
    .rdata_valid_out (rdata_valid_out),
    .stall_out       (stall_out),
    .fault_out       (fault_out),
    .fault_addr_out  (fault_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rdata_valid_out === 1'b1) vcnt++;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference byte-array memory; misaligned halfword/word addresses are rounded down.
  function automatic logic [11:0] align(input logic [31:0] a, input logic [1:0] sz);
    logic [11:0] r;
    r = a[11:0];
    if (sz == SZ_H) r[0] = 1'b0;
    if (sz == SZ_W) r[1:0] = 2'b00;
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic s);
    logic [11:0] i;
    logic [7:0]  b;
    logic [15:0] h;
    i = align(a, sz);
    b = mem_m[i];
    h = {mem_m[i+12'd1], mem_m[i]};
    if (sz == SZ_B) return s ? {{24{b[7]}}, b} : {24'd0, b};
    if (sz == SZ_H) return s ? {{16{h[15]}}, h} : {16'd0, h};
    return {mem_m[i+12'd3], mem_m[i+12'd2], mem_m[i+12'd1], mem_m[i]};
  endfunction

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    logic [11:0] i;
    addr = a; wdata = d; size = sz; we = 1'b1; re = 1'b0;
    #1 checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL store_stall got %b exp 0", stall_out); end
    i = align(a, sz);
    mem_m[i] = d[7:0];
    if (sz != SZ_B) mem_m[i+12'd1] = d[15:8];
    if (sz == SZ_W) begin mem_m[i+12'd2] = d[23:16]; mem_m[i+12'd3] = d[31:24]; end
    @(negedge clk); we = 1'b0;
    #1 checks++;
    if (fault_out !== 1'b0) begin errors++; $display("FAIL store_fault got %b exp 0", fault_out); end
  endtask

  task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic s, input logic [31:0] e);
    logic [31:0] x;
    addr = a; size = sz; sgn = s; re = 1'b1; we = 1'b0;
    exp_q.push_back(e);
    #1 checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL load_stall_n0 got %b exp 1", stall_out); end
    @(negedge clk); re = 1'b0;
    #1 checks++;
    if (stall_out !== 1'b1 || rdata_valid_out !== 1'b0) begin
      errors++; $display("FAIL load_n1 stall/valid got %b%b exp 10", stall_out, rdata_valid_out);
    end
    @(negedge clk);
    #1 checks++;
    x = exp_q.pop_front();
    if (rdata_valid_out !== 1'b1 || stall_out !== 1'b0) begin
      errors++; $display("FAIL load_n2 valid/stall got %b%b exp 10", rdata_valid_out, stall_out);
    end else begin
      checks++;
      if (rdata_out !== x) begin errors++; $display("FAIL load_data addr %h got %h exp %h", a, rdata_out, x); end
    end
    @(negedge clk);
    #1 checks++;
    if (rdata_valid_out !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b exp 0", rdata_valid_out); end
  endtask

  task automatic do_fault(input logic [31:0] a, input logic r, input logic w, input logic [1:0] sz);
    int v0;
    v0 = vcnt;
    addr = a; re = r; we = w; size = sz; wdata = 32'hFFFF_FFFF; sgn = 1'b0;
    #1 checks++;
    if (stall_out !== 1'b0) begin errors++; $display("FAIL fault_stall got %b exp 0", stall_out); end
    @(negedge clk); re = 1'b0; we = 1'b0;
    #1 checks++;
    if (fault_out !== 1'b1 || fault_addr_out !== a) begin
      errors++; $display("FAIL fault_pulse got %b/%h exp 1/%h", fault_out, fault_addr_out, a);
    end
    @(negedge clk);
    #1 checks++;
    if (fault_out !== 1'b0 || vcnt != v0) begin
      errors++; $display("FAIL fault_after got %b/%0d exp 0/%0d", fault_out, vcnt, v0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; re = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0; size = SZ_W; sgn = 1'b0;
    @(negedge clk); #1 checks++;
    if (rdata_out !== 32'd0 || rdata_valid_out !== 1'b0 || stall_out !== 1'b0 ||
        fault_out !== 1'b0 || fault_addr_out !== 32'd0) begin
      errors++; $display("FAIL reset_vals got %h %b %b %b %h exp 0", rdata_out, rdata_valid_out,
                         stall_out, fault_out, fault_addr_out);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_word();
    do_store(32'h40, 32'hDEAD_BEEF, SZ_W);
    do_load(32'h40, SZ_W, 1'b0, 32'hDEAD_BEEF);
  endtask

  task automatic test_byte();
    do_store(32'h40, 32'h0, SZ_W);
    do_store(32'h43, 32'h1234_5680, SZ_B);
    do_load(32'h43, SZ_B, 1'b1, 32'hFFFF_FF80);
    do_load(32'h43, SZ_B, 1'b0, 32'h0000_0080);
    do_load(32'h40, SZ_W, 1'b0, 32'h8000_0000);
  endtask

  task automatic test_halfword();
    do_store(32'h40, 32'hAAAA_AAAA, SZ_W);
    do_store(32'h42, 32'hCAFE_1234, SZ_H);
    do_load(32'h40, SZ_W, 1'b1, 32'h1234_AAAA);
    do_load(32'h42, SZ_H, 1'b1, 32'h0000_1234);
    do_store(32'h40, 32'h0000_F00D, SZ_H);
    do_load(32'h40, SZ_H, 1'b1, 32'hFFFF_F00D);
    do_load(32'h40, SZ_H, 1'b0, 32'h0000_F00D);
    do_load(32'h40, SZ_W, 1'b0, 32'h1234_F00D);
  endtask

  task automatic test_misaligned();
`ifdef DMEM_MISALIGN_TRAP_EN
    do_fault(32'h41, 1'b1, 1'b0, SZ_W);
    do_fault(32'h43, 1'b0, 1'b1, SZ_H);
`else
    do_load(32'h41, SZ_W, 1'b0, 32'h1234_F00D);
    do_store(32'h43, 32'h0000_5678, SZ_H);
`endif
    do_load(32'h40, SZ_W, 1'b0, ref_load(32'h40, SZ_W, 1'b0));
  endtask

  task automatic test_illegal();
    do_fault(32'h8000_0040, 1'b1, 1'b1, SZ_W);
    do_fault(32'h0000_0044, 1'b0, 1'b1, 2'b10);
    do_fault(32'h0000_0048, 1'b1, 1'b0, 2'b10);
    do_load(32'h40, SZ_W, 1'b0, ref_load(32'h40, SZ_W, 1'b0));
  endtask

  task automatic test_reset_in_load();
    int v0;
    v0 = vcnt;
    addr = 32'h40; size = SZ_W; sgn = 1'b0; re = 1'b1; we = 1'b0;
    @(negedge clk); re = 1'b0;
    #1 checks++;
    if (stall_out !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b exp 1", stall_out); end
    #1 rst = 1'b1;
    #1 checks++;
    if (stall_out !== 1'b0 || rdata_valid_out !== 1'b0) begin
      errors++; $display("FAIL rst_mid_load stall/valid got %b%b exp 00", stall_out, rdata_valid_out);
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); @(negedge clk); #1 checks++;
    if (vcnt != v0) begin errors++; $display("FAIL rst_no_valid got %0d exp %0d", vcnt, v0); end
    do_load(32'h40, SZ_W, 1'b0, ref_load(32'h40, SZ_W, 1'b0));
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  sz;
    logic        s;
    for (int i = 0; i < 16; i++) do_store(32'h100 + 32'(i * 4), $urandom, SZ_W);
    for (int i = 0; i < 30; i++) begin
      a  = 32'h100 + 32'($urandom_range(0, 63));
      sz = (i % 3 == 0) ? SZ_B : ((i % 3 == 1) ? SZ_H : SZ_W);
      if (sz == SZ_H) a[0] = 1'b0;
      if (sz == SZ_W) a[1:0] = 2'b00;
      s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) do_store(a, $urandom, sz);
      else do_load(a, sz, s, ref_load(a, sz, s));
    end
    do_store(32'h0000_1200, 32'h0BAD_F00D, SZ_W);
    do_load(32'h0000_0200, SZ_W, 1'b0, 32'h0BAD_F00D);
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_halfword();
    test_misaligned();
    test_illegal();
    test_reset_in_load();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the single-cycle MIPS datapath. It sits on the far end of the control decoder's data-memory signals (read enable, write enable, size, signed) and the ALU address result. It owns a byte-addressable synchronous RAM and performs byte, halfword and word loads and stores, including lane steering and sign or zero extension. It stalls the PC across the multi-cycle load sequence and flags misaligned or illegal requests.

## Interface
- `ADDR_WIDTH`, default 10: word-index bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- `clk`  in  1  sole clock; rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `addr_in`  in  32  byte address from the ALU.
- `wdata_in`  in  32  store data (rt).
- `re_in`  in  1  load request, level.
- `we_in`  in  1  store request, level.
- `size_in`  in  2  access size: 00 byte, 01 halfword, 11 word, 10 illegal.
- `signed_in`  in  1  load extension: 1 sign-extend, 0 zero-extend.
- `rdata_out`  out  32  formatted load result (registered).
- `rdata_valid_out`  out  1  one-cycle pulse; `rdata_out` is valid.
- `stall_out`  out  1  hold the PC; drives the PC enable low.
- `fault_out`  out  1  one-cycle pulse on a rejected request.
- `fault_addr_out`  out  32  address of the last faulting request (registered).

## Operation
- Byte order is little-endian: byte lane k = bits [8k+7:8k], selected by `addr_in[1:0]`.
- The word index is `addr_in[ADDR_WIDTH+1:2]`. Higher address bits are ignored, so addresses wrap modulo RAM size.
- Requests are sampled only in the IDLE state. Inputs presented while the block is not in IDLE are ignored.
- **Store** (we_in=1, re_in=0, legal):
  - Completes in one cycle with no stall.
  - Byte store: `wdata_in[7:0]` is written to the lane selected by `addr[1:0]`.
  - Halfword store: `wdata_in[15:0]` is written to lane pair `addr[1]`.
  - Word store: all four lanes are written.
  - Lanes not being written are unchanged.
- **Load** (re_in=1, we_in=0, legal): FSM sequence IDLE → LOAD → DONE → IDLE.
  - IDLE: the RAM read is issued, and `addr[1:0]`, size and signed are captured.
  - LOAD: the RAM word is available. It is lane-selected, extended, and registered into `rdata_out`.
  - DONE: `rdata_valid_out`=1 and `stall_out`=0. Requests are ignored in DONE because the same instruction is still presented.
- **Illegal request**: re_in and we_in both high, or size_in=10.
  - `fault_out` pulses and `fault_addr_out` is updated.
  - No RAM access and no stall.
- **Misaligned request**: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0. Handling is per Configuration.
- Word loads ignore `signed_in`.
- `rdata_out` holds its value until the next load completes.

## Timing
- **Reset values**:
  - State = IDLE.
  - `rdata_out`=0, `rdata_valid_out`=0, `fault_out`=0, `fault_addr_out`=0.
  - `stall_out`=0.
  - RAM contents are not reset.
- `stall_out` is combinational: 1 when (IDLE and a legal load is requested) or state=LOAD; otherwise 0.
- **Load latency**: request in cycle N. `stall_out` is high in N and N+1. `rdata_out` and `rdata_valid_out` are valid in N+2, with the PC advancing at the end of N+2. Throughput is one load per 3 cycles.
- **Store latency**: the RAM is written at the end of the request cycle. A load to the same address in the next cycle returns the new data.
- `fault_out` is registered: it is high in N+1 for a rejected request sampled in N.
- **Reset asserted mid-load**: return to IDLE immediately, with no valid pulse and the stall dropped. A store in flight at the reset edge is not guaranteed.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined: a misaligned request is rejected like an illegal one. It raises `fault_out`, latches `fault_addr_out`, makes no access and does not stall.
- Undefined: the low address bits are forced to zero (halfword `addr[0]`, word `addr[1:0]`) and the access proceeds normally. `fault_out` is raised only for illegal requests.

## Structure
- **Shared package `dmem_pkg`**:
  - Size constants SIZE_BYTE=00, SIZE_HW=01, SIZE_WORD=11. These must match the control decoder's encodings.
  - FSM state enum: IDLE, LOAD, DONE.
- **Sub-module `dmem_ram`**:
  - Synchronous single-port RAM, 2^ADDR_WIDTH × 32.
  - 4-bit byte-write enable and registered read data.
  - `data_mem_ctrl` contains the FSM, lane steering, extension and fault logic.

## Test plan
- **Word store then load**: store 0xDEADBEEF to 0x40, then load the word from 0x40. Expect `stall_out` high 2 cycles, then `rdata_out`=0xDEADBEEF with `rdata_valid_out` high 1 cycle.
- **Byte store and signed/unsigned load**: store byte 0x80 to 0x43 over a zero word. Expect lb 0x43 = 0xFFFFFF80, lbu 0x43 = 0x00000080, and lw 0x40 = 0x80000000.
- **Halfword**: store halfword 0x1234 to 0x42 over 0xAAAAAAAA. Expect lw 0x40 = 0x1234AAAA, and lh 0x42 = 0x00001234.
- **Misaligned word load from 0x41**:
  - Trap build: `fault_out` pulses, `fault_addr_out`=0x41, no stall, no valid pulse.
  - Non-trap build: returns the word at 0x40.
- **Illegal request**: re_in=we_in=1, or size_in=10. Expect `fault_out` to pulse, memory unchanged, no stall.
- **Reset in LOAD**: assert `rst` in cycle N+1 of a load. Expect `stall_out`=0 at once, no valid pulse, and a subsequent load behaving normally.
